// File: rtl/if_pkg.sv
// Shared types and constants for the instruction-fetch stage.
package if_pkg;

  localparam int PC_W = 32;
  localparam logic [PC_W-1:0] PC_INC = 32'd4;
  localparam logic [31:0] NOP_WORD = 32'h0000_0013;  // addi x0,x0,0

  typedef enum logic [1:0] {
    FETCH = 2'd0,
    HOLD  = 2'd1,
    DRAIN = 2'd2
  } fetch_state_t;

  function automatic logic [PC_W-1:0] align_word(input logic [PC_W-1:0] a);
    return a & ~32'd3;
  endfunction

endpackage

// File: rtl/if_id_reg.sv
// IF/ID pipeline register {valid, pc, instruction} with load, flush and hold.
module if_id_reg
  import if_pkg::*;
#(
  parameter logic [31:0] NOP_INSTR = NOP_WORD
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            load,
  input  logic            flush,
  input  logic [PC_W-1:0] pc_in,
  input  logic [31:0]     instr_in,
  output logic [31:0]     instr,
  output logic [PC_W-1:0] pc,
  output logic            valid
);

  logic [64:0] id_q;

  // Flush wins over load; the PC field is left alone on a bubble.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      id_q <= {1'b0, 32'h0, NOP_INSTR};
    end else if (flush) begin
      id_q <= {1'b0, id_q[63:32], NOP_INSTR};
    end else if (load) begin
      id_q <= {1'b1, pc_in, instr_in};
    end
  end

  assign valid = id_q[64];
  assign pc    = id_q[63:32];
  assign instr = id_q[31:0];

endmodule

// File: rtl/if_stage.sv
// Instruction-fetch stage: PC, imem request FSM, stall buffer and IF/ID register.
module if_stage
  import if_pkg::*;
#(
  parameter logic [PC_W-1:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0]     NOP_INSTR = NOP_WORD
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            IFWrite,
  input  logic            Branch,
  input  logic            Jump,
  input  logic [PC_W-1:0] JumpAddr,
  output logic            imem_req,
  output logic [PC_W-1:0] imem_addr,
  input  logic            imem_ready,
  input  logic [31:0]     imem_rdata,
  output logic [31:0]     Instruction_id,
  output logic [PC_W-1:0] PC_id,
  output logic            Valid_id,
  output fetch_state_t    state_dbg
);

  fetch_state_t    state;
  logic [PC_W-1:0] pc;
  logic [PC_W-1:0] redirect_pc;
  logic [PC_W-1:0] buf_pc;
  logic [31:0]     buf_instr;
  logic            armed;

  logic            redirect;
  logic [PC_W-1:0] target;
  logic            resp;
  logic            id_load;
  logic            id_flush;
  logic [PC_W-1:0] id_pc;
  logic [31:0]     id_instr;

  // Handshake: imem_req/imem_addr hold steady until a cycle with imem_ready=1,
  // which completes exactly one transfer; imem_ready is ignored while imem_req=0.
  assign imem_req  = armed && (state != HOLD);
  assign imem_addr = pc;
  assign resp      = imem_req && imem_ready;
  assign redirect  = IFWrite && (Branch || Jump);
  assign target    = align_word(JumpAddr);
  assign state_dbg = state;

  always_comb begin
    id_load  = 1'b0;
    id_flush = 1'b0;
    id_pc    = pc;
    id_instr = imem_rdata;
    case (state)
      FETCH: begin
        if (resp) begin
          if (redirect)     id_flush = 1'b1;
          else if (IFWrite) id_load  = 1'b1;
        end else if (IFWrite) begin
          id_flush = 1'b1;
        end
      end
      HOLD: begin
        if (redirect) begin
          id_flush = 1'b1;
        end else if (IFWrite) begin
          id_load  = 1'b1;
          id_pc    = buf_pc;
          id_instr = buf_instr;
        end
      end
      DRAIN: id_flush = IFWrite;
      default: ;
    endcase
  end

  // armed keeps the first post-reset cycle request-free so a stale response is never taken.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= FETCH;
      pc          <= RESET_PC;
      redirect_pc <= RESET_PC;
      buf_pc      <= '0;
      buf_instr   <= NOP_INSTR;
      armed       <= 1'b0;
    end else begin
      armed <= 1'b1;
      case (state)
        FETCH: begin
          if (resp) begin
            if (redirect) begin
              pc <= target;
            end else begin
              pc <= pc + PC_INC;
              if (!IFWrite) begin
                buf_pc    <= pc;
                buf_instr <= imem_rdata;
                state     <= HOLD;
              end
            end
          end else if (redirect) begin
            if (imem_req) begin
              redirect_pc <= target;
              state       <= DRAIN;
            end else begin
              pc <= target;
            end
          end
        end
        HOLD: begin
          if (redirect) begin
            pc    <= target;
            state <= FETCH;
          end else if (IFWrite) begin
            state <= FETCH;
          end
        end
        DRAIN: begin
          if (resp) begin
            pc    <= redirect ? target : redirect_pc;
            state <= FETCH;
          end else if (redirect) begin
            redirect_pc <= target;
          end
        end
        default: state <= FETCH;
      endcase
    end
  end

  if_id_reg #(.NOP_INSTR(NOP_INSTR)) u_if_id_reg (
    .clk      (clk),
    .reset    (reset),
    .load     (id_load),
    .flush    (id_flush),
    .pc_in    (id_pc),
    .instr_in (id_instr),
    .instr    (Instruction_id),
    .pc       (PC_id),
    .valid    (Valid_id)
  );

endmodule

// File: tb/tb_if_stage.sv
// Bench for if_stage: directed cycle table, reset-abort sequence, random program-order check.
module tb_if_stage;
  import if_pkg::*;

  localparam logic [31:0] K   = 32'hA5A5_0000;
  localparam logic [31:0] NOP = 32'h0000_0013;

  logic         clk = 1'b0;
  logic         reset;
  logic         IFWrite, Branch, Jump, imem_ready;
  logic [31:0]  JumpAddr, imem_rdata, imem_addr, Instruction_id, PC_id;
  logic         imem_req, Valid_id;
  fetch_state_t state_dbg;

  int checks   = 0;
  int failures = 0;

  if_stage dut (
    .clk            (clk),
    .reset          (reset),
    .IFWrite        (IFWrite),
    .Branch         (Branch),
    .Jump           (Jump),
    .JumpAddr       (JumpAddr),
    .imem_req       (imem_req),
    .imem_addr      (imem_addr),
    .imem_ready     (imem_ready),
    .imem_rdata     (imem_rdata),
    .Instruction_id (Instruction_id),
    .PC_id          (PC_id),
    .Valid_id       (Valid_id),
    .state_dbg      (state_dbg)
  );

  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout, want completion");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h, want %h", name, act, exp);
    end
  endtask

  task automatic drive(input logic ifw, input logic br, input logic jmp,
                       input logic [31:0] ja, input logic rdy);
    IFWrite    = ifw;
    Branch     = br;
    Jump       = jmp;
    JumpAddr   = ja;
    imem_ready = rdy;
    imem_rdata = rdy ? (imem_addr ^ K) : $urandom;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    @(negedge clk);
  endtask

  typedef struct {
    logic         ifw, br, jmp;
    logic [31:0]  jaddr;
    logic         rdy;
    logic         e_req;
    logic [31:0]  e_addr;
    logic         e_valid;
    logic [31:0]  e_pc;
    fetch_state_t e_state;
  } vec_t;

  vec_t vt[22];

  logic [31:0] exp_next, jr;
  logic        prev_pending, ifw_r, br_r, jmp_r, rdy_r;
  logic [31:0] prev_addr;
  int          consumed;

  initial begin
    // Cycle script from first post-reset cycle: sequential fetch, stall/HOLD,
    // jump, redirect during a slow response (DRAIN), ignored branch under stall, PC wrap.
    vt[0]  = '{1'b1, 1'b0, 1'b0, 32'h0,         1'b1, 1'b0, 32'h0,         1'b0, 32'h0,         FETCH};
    vt[1]  = '{1'b1, 1'b0, 1'b0, 32'h0,         1'b1, 1'b1, 32'h0,         1'b0, 32'h0,         FETCH};
    vt[2]  = '{1'b1, 1'b0, 1'b0, 32'h0,         1'b1, 1'b1, 32'h4,         1'b1, 32'h0,         FETCH};
    vt[3]  = '{1'b1, 1'b0, 1'b0, 32'h0,         1'b1, 1'b1, 32'h8,         1'b1, 32'h4,         FETCH};
    vt[4]  = '{1'b0, 1'b0, 1'b0, 32'h0,         1'b1, 1'b1, 32'hC,         1'b1, 32'h8,         FETCH};
    vt[5]  = '{1'b0, 1'b0, 1'b0, 32'h0,         1'b1, 1'b0, 32'h0,         1'b1, 32'h8,         HOLD};
    vt[6]  = '{1'b1, 1'b0, 1'b0, 32'h0,         1'b1, 1'b0, 32'h0,         1'b1, 32'h8,         HOLD};
    vt[7]  = '{1'b1, 1'b0, 1'b0, 32'h0,         1'b1, 1'b1, 32'h10,        1'b1, 32'hC,         FETCH};
    vt[8]  = '{1'b1, 1'b0, 1'b1, 32'h103,       1'b1, 1'b1, 32'h14,        1'b1, 32'h10,        FETCH};
    vt[9]  = '{1'b1, 1'b0, 1'b0, 32'h0,         1'b1, 1'b1, 32'h100,       1'b0, 32'h0,         FETCH};
    vt[10] = '{1'b1, 1'b0, 1'b1, 32'h20,        1'b1, 1'b1, 32'h104,       1'b1, 32'h100,       FETCH};
    vt[11] = '{1'b1, 1'b1, 1'b0, 32'h200,       1'b0, 1'b1, 32'h20,        1'b0, 32'h0,         FETCH};
    vt[12] = '{1'b1, 1'b0, 1'b0, 32'h0,         1'b0, 1'b1, 32'h20,        1'b0, 32'h0,         DRAIN};
    vt[13] = '{1'b1, 1'b0, 1'b0, 32'h0,         1'b0, 1'b1, 32'h20,        1'b0, 32'h0,         DRAIN};
    vt[14] = '{1'b1, 1'b0, 1'b0, 32'h0,         1'b1, 1'b1, 32'h20,        1'b0, 32'h0,         DRAIN};
    vt[15] = '{1'b0, 1'b1, 1'b0, 32'h400,       1'b0, 1'b1, 32'h200,       1'b0, 32'h0,         FETCH};
    vt[16] = '{1'b1, 1'b0, 1'b0, 32'h0,         1'b1, 1'b1, 32'h200,       1'b0, 32'h0,         FETCH};
    vt[17] = '{1'b1, 1'b0, 1'b1, 32'hFFFF_FFFF, 1'b1, 1'b1, 32'h204,       1'b1, 32'h200,       FETCH};
    vt[18] = '{1'b1, 1'b0, 1'b0, 32'h0,         1'b1, 1'b1, 32'hFFFF_FFFC, 1'b0, 32'h0,         FETCH};
    vt[19] = '{1'b1, 1'b0, 1'b0, 32'h0,         1'b1, 1'b1, 32'h0,         1'b1, 32'hFFFF_FFFC, FETCH};
    vt[20] = '{1'b1, 1'b0, 1'b0, 32'h0,         1'b0, 1'b1, 32'h4,         1'b1, 32'h0,         FETCH};
    vt[21] = '{1'b1, 1'b0, 1'b0, 32'h0,         1'b0, 1'b1, 32'h4,         1'b0, 32'h0,         FETCH};

    reset = 1'b1;
    drive(1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("reset_req", 32'(imem_req), 32'h0);
    chk("reset_valid", 32'(Valid_id), 32'h0);
    chk("reset_instr", Instruction_id, NOP);
    chk("reset_pc_id", PC_id, 32'h0);
    reset = 1'b0;

    for (int i = 0; i < 22; i++) begin
      chk($sformatf("v%0d_req", i), 32'(imem_req), 32'(vt[i].e_req));
      chk($sformatf("v%0d_state", i), 32'(state_dbg), 32'(vt[i].e_state));
      chk($sformatf("v%0d_valid", i), 32'(Valid_id), 32'(vt[i].e_valid));
      if (vt[i].e_req) chk($sformatf("v%0d_addr", i), imem_addr, vt[i].e_addr);
      if (vt[i].e_valid) begin
        chk($sformatf("v%0d_pc_id", i), PC_id, vt[i].e_pc);
        chk($sformatf("v%0d_instr", i), Instruction_id, vt[i].e_pc ^ K);
      end else begin
        chk($sformatf("v%0d_nop", i), Instruction_id, NOP);
      end
      drive(vt[i].ifw, vt[i].br, vt[i].jmp, vt[i].jaddr, vt[i].rdy);
      next_cycle();
    end

    // Reset in the middle of a DRAIN, with a stale response arriving after release.
    drive(1'b1, 1'b0, 1'b1, 32'h300, 1'b0);
    next_cycle();
    chk("drain_state", 32'(state_dbg), 32'(DRAIN));
    drive(1'b1, 1'b0, 1'b0, 32'h0, 1'b0);
    #2 reset = 1'b1;
    #1;
    chk("abort_req", 32'(imem_req), 32'h0);
    chk("abort_valid", 32'(Valid_id), 32'h0);
    chk("abort_instr", Instruction_id, NOP);
    chk("abort_pc_id", PC_id, 32'h0);
    chk("abort_state", 32'(state_dbg), 32'(FETCH));
    next_cycle();
    reset      = 1'b0;
    imem_ready = 1'b1;
    imem_rdata = 32'hDEAD_BEEF;
    chk("post_rst_req", 32'(imem_req), 32'h0);
    next_cycle();
    chk("post_rst_req1", 32'(imem_req), 32'h1);
    chk("post_rst_addr", imem_addr, 32'h0);
    chk("post_rst_valid", 32'(Valid_id), 32'h0);
    drive(1'b1, 1'b0, 1'b0, 32'h0, 1'b1);
    next_cycle();
    chk("first_valid", 32'(Valid_id), 32'h1);
    chk("first_pc_id", PC_id, 32'h0);
    chk("first_instr", Instruction_id, K);

    // Random phase: decode must see the architectural program order.
    drive(1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
    reset = 1'b1;
    next_cycle();
    reset        = 1'b0;
    exp_next     = 32'h0;
    prev_pending = 1'b0;
    prev_addr    = 32'h0;
    consumed     = 0;
    for (int c = 0; c < 4000; c++) begin
      if (prev_pending) begin
        chk("hold_req", 32'(imem_req), 32'h1);
        chk("hold_addr", imem_addr, prev_addr);
      end
      ifw_r = ($urandom_range(0, 9) < 8);
      br_r  = ($urandom_range(0, 15) == 0);
      jmp_r = ($urandom_range(0, 15) == 0);
      rdy_r = ($urandom_range(0, 9) < 7);
      jr    = $urandom;
      if ($urandom_range(0, 3) == 0) jr = 32'hFFFF_FFF0 | (jr & 32'hF);
      drive(ifw_r, br_r, jmp_r, jr, rdy_r);
      if (ifw_r && Valid_id) begin
        chk("rand_pc_id", PC_id, exp_next);
        chk("rand_instr", Instruction_id, PC_id ^ K);
        consumed++;
        exp_next = (br_r || jmp_r) ? (jr & 32'hFFFF_FFFC) : PC_id + 32'd4;
      end else if (ifw_r && (br_r || jmp_r)) begin
        exp_next = jr & 32'hFFFF_FFFC;
      end
      prev_pending = imem_req && !rdy_r;
      prev_addr    = imem_addr;
      next_cycle();
    end
    chk("rand_progress", 32'(consumed > 1000), 32'h1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
